scoreboard_hazard_ctrl: RTL and testbench

SCOREBOARD_HAZARD_CTRL -- requirements
Module: scoreboard_hazard_ctrl

---
 rtl/scoreboard_hazard_ctrl_pkg.sv | 17 +
 rtl/scoreboard_hazard_ctrl_kill_seq.sv | 31 +++
 rtl/scoreboard_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_scoreboard_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_hazard_ctrl_pkg.sv
// Shared core constants for the decode-stage scoreboard: op classes and default latencies.
package scoreboard_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ALU  = 2'd1,
    OP_LOAD = 2'd2,
    OP_LONG = 2'd3
  } op_class_e;

  localparam int unsigned DEF_NREG        = 32;
  localparam int unsigned DEF_ALU_LAT     = 1;
  localparam int unsigned DEF_LOAD_LAT    = 2;
  localparam int unsigned DEF_CNT_W       = 3;
  localparam int unsigned DEF_KILL_CYCLES = 2;

endpackage

// File: rtl/scoreboard_hazard_ctrl_kill_seq.sv
// Kill sequencer: stretches a redirect into a KILL_CYCLES-long squash pulse, frozen while hold.
module kill_seq
  import scoreboard_hazard_ctrl_pkg::*;
#(
  parameter int unsigned KILL_CYCLES = DEF_KILL_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic redirect,
  input  logic hold,
  output logic kill
);

  localparam int unsigned KC_W = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

  logic [KC_W-1:0] kill_cnt;

  // Remaining kill cycles after the current one; a new redirect restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      kill_cnt <= '0;
    end else if (redirect && !hold) begin
      kill_cnt <= KC_W'(KILL_CYCLES - 1);
    end else if ((kill_cnt != '0) && !hold) begin
      kill_cnt <= kill_cnt - KC_W'(1);
    end
  end

  assign kill = !rst && !hold && (redirect || (kill_cnt != '0));

endmodule

// File: rtl/scoreboard_hazard_ctrl.sv
// Decode-stage register scoreboard: per-register readiness counters, a single long-latency
// unit tracker, and issue/stall/kill generation.
module scoreboard_hazard_ctrl
  import scoreboard_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NREG        = DEF_NREG,
  parameter int unsigned ALU_LAT     = DEF_ALU_LAT,
  parameter int unsigned LOAD_LAT    = DEF_LOAD_LAT,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned KILL_CYCLES = DEF_KILL_CYCLES,
  parameter int unsigned REG_W       = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [1:0]       op_class,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd,
  input  logic             rd_we,
  input  logic             long_done,
  input  logic             redirect,
  input  logic             hold,
  output logic             issue_fire,
  output logic             stall,
  output logic             kill,
  output logic             long_busy,
  output logic [NREG-1:0]  pending_mask
);

  op_class_e        op;
  logic [CNT_W-1:0] cnt [NREG];
  logic             long_busy_q;
  logic [REG_W-1:0] long_rd;
  logic [NREG-1:0]  pend;
  logic             hazard;
  logic             rd_wr;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             long_fire;

  assign op = op_class_e'(op_class);

  kill_seq #(
    .KILL_CYCLES(KILL_CYCLES)
  ) u_kill_seq (
    .clk     (clk),
    .rst     (rst),
    .redirect(redirect),
    .hold    (hold),
    .kill    (kill)
  );

  // Pending view of the pre-edge state; x0 is hardwired never-pending.
  always_comb begin
    pend = '0;
    for (int r = 1; r < int'(NREG); r++) begin
      pend[r] = (cnt[r] != '0) || (long_busy_q && (long_rd == REG_W'(r)));
    end
  end

  always_comb begin
    rd_wr  = rd_we && (rd != '0);
    hazard = (rs1_used && pend[rs1])
          || (rs2_used && pend[rs2])
          || (rd_wr && pend[rd])
          || ((op == OP_LONG) && long_busy_q);
    issue_fire = issue_valid && !hazard && !kill && !rst;
    stall      = issue_valid &&  hazard && !kill && !rst;
  end

  always_comb begin
    cnt_load     = issue_fire && rd_wr && ((op == OP_ALU) || (op == OP_LOAD));
    cnt_load_val = (op == OP_LOAD) ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
    long_fire    = issue_fire && (op == OP_LONG);
  end

  // Readiness counters: load on issue, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREG); r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NREG); r++) begin
        if (cnt_load && (rd == REG_W'(r))) begin
          cnt[r] <= cnt_load_val;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  // Long unit: a LONG without a real destination still occupies the unit but targets x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_busy_q <= 1'b0;
      long_rd     <= '0;
    end else if (long_fire) begin
      long_busy_q <= 1'b1;
      long_rd     <= rd_wr ? rd : '0;
    end else if (long_done && long_busy_q) begin
      long_busy_q <= 1'b0;
      long_rd     <= '0;
    end
  end

  assign long_busy    = long_busy_q && !rst;
  assign pending_mask = rst ? '0 : pend;

endmodule

// File: tb/tb_scoreboard_hazard_ctrl.sv
// Self-checking bench for scoreboard_hazard_ctrl: per-cycle expectations queued at drive time
// and compared at the following falling edge.
module tb_scoreboard_hazard_ctrl;
  import scoreboard_hazard_ctrl_pkg::*;

  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [1:0]       op_class;
  logic [REG_W-1:0] rs1, rs2, rd;
  logic             rs1_used, rs2_used, rd_we;
  logic             long_done, redirect, hold;
  logic             issue_fire, stall, kill, long_busy;
  logic [NREG-1:0]  pending_mask;
  logic             k1_fire, k1_stall, k1_kill, k1_busy;
  logic [NREG-1:0]  k1_mask;

  typedef struct packed {
    logic        fire;
    logic        stall;
    logic        kill;
    logic        busy;
    logic        kill1;
    logic [31:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  scoreboard_hazard_ctrl dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .op_class(op_class),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd(rd), .rd_we(rd_we), .long_done(long_done), .redirect(redirect), .hold(hold),
    .issue_fire(issue_fire), .stall(stall), .kill(kill), .long_busy(long_busy),
    .pending_mask(pending_mask)
  );

  scoreboard_hazard_ctrl #(.KILL_CYCLES(1)) dut_k1 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .op_class(op_class),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd(rd), .rd_we(rd_we), .long_done(long_done), .redirect(redirect), .hold(hold),
    .issue_fire(k1_fire), .stall(k1_stall), .kill(k1_kill), .long_busy(k1_busy),
    .pending_mask(k1_mask)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m(input int r);
    logic [31:0] one;
    one = 32'd1;
    return one << r;
  endfunction

  task automatic idle();
    issue_valid = 1'b0; op_class = 2'd0;
    rs1 = '0; rs2 = '0; rd = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; rd_we = 1'b0;
    long_done = 1'b0; redirect = 1'b0; hold = 1'b0;
  endtask

  task automatic set_op(input logic [1:0] oc, input int d, input logic we, input int s1,
                        input logic u1);
    issue_valid = 1'b1; op_class = oc;
    rd = REG_W'(d); rd_we = we;
    rs1 = REG_W'(s1); rs1_used = u1;
    rs2 = '0; rs2_used = 1'b0;
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic cyc(input string tag, input logic ef, input logic es, input logic ek,
                     input logic eb, input logic [31:0] em);
    exp_t e;
    e.fire  = ef;
    e.stall = es;
    e.kill  = ek;
    e.busy  = eb;
    e.kill1 = redirect && !hold && !rst;
    e.mask  = em;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check_val({tag, "/fire"},  32'(issue_fire),   32'(e.fire));
    check_val({tag, "/stall"}, 32'(stall),        32'(e.stall));
    check_val({tag, "/kill"},  32'(kill),         32'(e.kill));
    check_val({tag, "/busy"},  32'(long_busy),    32'(e.busy));
    check_val({tag, "/mask"},  32'(pending_mask), e.mask);
    check_val({tag, "/kill1"}, 32'(k1_kill),      32'(e.kill1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    cyc("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("idle", 0, 0, 0, 0, 0);

    // Load-use: LOAD x5 then ALU reading x5
    set_op(OP_LOAD, 5, 1, 0, 0);   cyc("ld_x5", 1, 0, 0, 0, 0);
    set_op(OP_ALU, 6, 1, 5, 1);    cyc("raw_c1", 0, 1, 0, 0, m(5));
    cyc("raw_c2", 0, 1, 0, 0, m(5));
    cyc("raw_c3", 1, 0, 0, 0, 0);
    idle();                        cyc("alu_x6", 0, 0, 0, 0, m(6));
    cyc("alu_done", 0, 0, 0, 0, 0);

    // Long unit occupancy and same-cycle long_done
    set_op(OP_LONG, 7, 1, 0, 0);   cyc("long_x7", 1, 0, 0, 0, 0);
    set_op(OP_LONG, 9, 1, 0, 0);   cyc("long2_stall", 0, 1, 0, 1, m(7));
    set_op(OP_ALU, 10, 1, 7, 1);   cyc("rd_x7_stall", 0, 1, 0, 1, m(7));
    set_op(OP_LONG, 9, 1, 0, 0);
    long_done = 1'b1;              cyc("done_same", 0, 1, 0, 1, m(7));
    long_done = 1'b0;              cyc("long2_fire", 1, 0, 0, 0, 0);
    set_op(OP_ALU, 10, 1, 7, 1);   cyc("rd_x7_fire", 1, 0, 0, 1, m(9));
    idle(); long_done = 1'b1;      cyc("done_x9", 0, 0, 0, 1, m(9) | m(10));
    long_done = 1'b0;              cyc("long_idle", 0, 0, 0, 0, 0);

    // LONG without a real destination
    set_op(OP_LONG, 0, 1, 0, 0);   cyc("long_x0", 1, 0, 0, 0, 0);
    idle();                        cyc("long_x0_busy", 0, 0, 0, 1, 0);
    set_op(OP_LONG, 11, 1, 0, 0);  cyc("long_busy_stall", 0, 1, 0, 1, 0);
    idle(); long_done = 1'b1;      cyc("done_x0", 0, 0, 0, 1, 0);
    cyc("stray_done", 0, 0, 0, 0, 0);
    long_done = 1'b0;
    set_op(OP_LONG, 11, 1, 0, 0);  cyc("long_x11", 1, 0, 0, 0, 0);
    idle(); long_done = 1'b1;      cyc("done_x11", 0, 0, 0, 1, m(11));
    long_done = 1'b0;              cyc("x11_free", 0, 0, 0, 0, 0);

    // Redirect kill with instruction held valid
    set_op(OP_LONG, 12, 1, 0, 0);  cyc("long_x12", 1, 0, 0, 0, 0);
    set_op(OP_ALU, 13, 1, 12, 1);
    redirect = 1'b1;               cyc("kill1", 0, 0, 1, 1, m(12));
    redirect = 1'b0;               cyc("kill2", 0, 0, 1, 1, m(12));
    cyc("post_kill", 0, 1, 0, 1, m(12));
    set_op(OP_LOAD, 14, 1, 0, 0);
    redirect = 1'b1;               cyc("kill_ld", 0, 0, 1, 1, m(12));
    idle();                        cyc("kill_ld2", 0, 0, 1, 1, m(12));
    cyc("no_x14", 0, 0, 0, 1, m(12));
    redirect = 1'b1;               cyc("rs_a", 0, 0, 1, 1, m(12));
    cyc("rs_b", 0, 0, 1, 1, m(12));
    redirect = 1'b0;               cyc("rs_c", 0, 0, 1, 1, m(12));
    cyc("rs_d", 0, 0, 0, 1, m(12));
    long_done = 1'b1;              cyc("done_x12", 0, 0, 0, 1, m(12));
    long_done = 1'b0;              cyc("x12_free", 0, 0, 0, 0, 0);

    // Hold suppresses kill and freezes the residual count
    hold = 1'b1; redirect = 1'b1;
    cyc("hold_a", 0, 0, 0, 0, 0);
    cyc("hold_b", 0, 0, 0, 0, 0);
    cyc("hold_c", 0, 0, 0, 0, 0);
    hold = 1'b0; redirect = 1'b0;  cyc("hold_rel", 0, 0, 0, 0, 0);
    redirect = 1'b1;               cyc("fz_a", 0, 0, 1, 0, 0);
    redirect = 1'b0; hold = 1'b1;  cyc("fz_b", 0, 0, 0, 0, 0);
    cyc("fz_c", 0, 0, 0, 0, 0);
    hold = 1'b0;                   cyc("fz_d", 0, 0, 1, 0, 0);
    cyc("fz_e", 0, 0, 0, 0, 0);

    // x0 is never pending
    set_op(OP_ALU, 0, 1, 0, 0);    cyc("alu_x0", 1, 0, 0, 0, 0);
    set_op(OP_ALU, 0, 1, 0, 1);
    rs2_used = 1'b1;               cyc("rd_x0", 1, 0, 0, 0, 0);
    set_op(OP_LOAD, 0, 1, 0, 0);   cyc("ld_x0", 1, 0, 0, 0, 0);
    idle();                        cyc("x0_idle", 0, 0, 0, 0, 0);

    // Reset mid-operation
    set_op(OP_LOAD, 3, 1, 0, 0);   cyc("ld_x3", 1, 0, 0, 0, 0);
    set_op(OP_LONG, 8, 1, 0, 0);   cyc("long_x8", 1, 0, 0, 0, m(3));
    idle(); rst = 1'b1;            cyc("mid_rst", 0, 0, 0, 0, 0);
    rst = 1'b0;                    cyc("post_rst", 0, 0, 0, 0, 0);
    long_done = 1'b1;              cyc("late_done", 0, 0, 0, 0, 0);
    long_done = 1'b0;
    set_op(OP_ALU, 4, 1, 3, 1);    cyc("x3_free", 1, 0, 0, 0, 0);
    set_op(OP_LONG, 8, 1, 0, 0);   cyc("long_after_rst", 1, 0, 0, 0, m(4));
    idle();                        cyc("x8_busy", 0, 0, 0, 1, m(8));
    long_done = 1'b1;              cyc("done_x8", 0, 0, 0, 1, m(8));
    long_done = 1'b0;              cyc("end_idle", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
